// File: rtl/serial_frame_deser.sv
// rtl/serial_frame_deser.sv - sync-word hunting serial deserializer with byte FIFO and sticky status
// Optional trailing even-parity bit per byte and parity_err port: SERIAL_FRAME_DESER_PARITY_EN
`timescale 1ns/1ps
module serial_frame_deser #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         FRAME_BYTES = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       sof_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       overflow,
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       clear_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    typedef enum logic {S_HUNT, S_DATA} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_hunt, r_shift, r_byte_cnt;
    logic [3:0]  r_bit_cnt;
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_overflow;
    logic [7:0]  w_hunt_next, w_shift_next;
    logic        w_sync_hit, w_byte_done, w_frame_done, w_parity_bad;
    logic        w_empty, w_full, w_pop, w_push_ok, w_drop;

    assign w_hunt_next  = {r_hunt[6:0], bit_in};
    assign w_shift_next = {r_shift[6:0], bit_in};
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop        = !w_empty && byte_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok    = w_byte_done && (!w_full || w_pop);
    assign w_drop       = w_byte_done && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_HUNT;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sync_hit   = 1'b0;
        w_byte_done  = 1'b0;
        w_frame_done = 1'b0;
        w_parity_bad = 1'b0;
        if (ena) begin
            case (r_state)
                S_HUNT: begin
                    if (w_hunt_next == SYNC_WORD) begin
                        w_sync_hit   = 1'b1;
                        w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    w_byte_done = (r_bit_cnt == 4'd7);
`ifdef SERIAL_FRAME_DESER_PARITY_EN
                    w_parity_bad = (r_bit_cnt == 4'd8) && ((^r_shift) ^ bit_in);
`endif
                    if (r_bit_cnt == LAST_BIT && r_byte_cnt == LAST_BYTE) begin
                        w_frame_done = 1'b1;
                        w_state_next = S_HUNT;
                    end
                end
                default: w_state_next = S_HUNT;
            endcase
        end
    end

    // Hunt register is zeroed on sync so the sync bits never seed the next search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hunt     <= 8'h00;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 4'd0;
            r_byte_cnt <= 8'd0;
        end else if (ena) begin
            if (r_state == S_HUNT) begin
                r_hunt     <= w_sync_hit ? 8'h00 : w_hunt_next;
                r_bit_cnt  <= 4'd0;
                r_byte_cnt <= 8'd0;
            end else begin
                if (r_bit_cnt < 4'd8) r_shift <= w_shift_next;
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt  <= 4'd0;
                    r_byte_cnt <= w_frame_done ? 8'd0 : r_byte_cnt + 8'd1;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= {(r_byte_cnt == 8'd0), w_shift_next};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)         r_overflow <= 1'b1;
            else if (clear_err) r_overflow <= 1'b0;
        end
    end

`ifdef SERIAL_FRAME_DESER_PARITY_EN
    logic r_parity_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_parity_err <= 1'b0;
        else if (w_parity_bad) r_parity_err <= 1'b1;
        else if (clear_err)    r_parity_err <= 1'b0;
    end
    assign parity_err = r_parity_err;
`endif

    assign byte_valid          = !w_empty;
    assign {sof_out, byte_out} = w_empty ? 9'd0 : r_mem[r_rd_ptr[AW-1:0]];
    assign locked              = (r_state == S_DATA);
    assign overflow            = r_overflow;

endmodule

// File: tb/tb_serial_frame_deser.sv
// tb/tb_serial_frame_deser.sv - directed and randomized checks of serial_frame_deser against a bit-stream parser model
`timescale 1ns/1ps
module tb_serial_frame_deser;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0, bit_in = 1'b0;
    logic byte_ready = 1'b0, clear_err = 1'b0;
    logic [7:0] byte_out;
    logic sof_out, byte_valid, locked, overflow;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    logic parity_err;
`endif

    int total = 0, bad = 0;
    logic [8:0] rx[$];
    logic [8:0] exp_q[$];
    bit         stream[$];

    always #5 clk = ~clk;

    serial_frame_deser dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in),
        .byte_out(byte_out), .sof_out(sof_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .locked(locked), .overflow(overflow),
`ifdef SERIAL_FRAME_DESER_PARITY_EN
        .parity_err(parity_err),
`endif
        .clear_err(clear_err)
    );

    always @(negedge clk) if (rst_n && byte_valid && byte_ready) rx.push_back({sof_out, byte_out});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic e);
        bit_in = b;
        ena    = e;
        if (e) stream.push_back(b);
        @(posedge clk); #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input bit gap);
        for (int k = n - 1; k >= 0; k--) begin
            if (gap) step(logic'($urandom_range(0, 1)), 1'b0);
            step(v[k], 1'b1);
        end
    endtask

    task automatic send_par(input logic [7:0] v, input bit gap);
`ifdef SERIAL_FRAME_DESER_PARITY_EN
        send_bits({7'd0, ^v}, 1, gap);
`endif
    endtask

    task automatic send_data(input logic [7:0] v, input bit gap);
        send_bits(v, 8, gap);
        send_par(v, gap);
    endtask

    task automatic do_reset();
        ena = 1'b0; clear_err = 1'b0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        stream.delete(); rx.delete();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        ena = 1'b0; byte_ready = 1'b1;
        for (int c = 0; c < 64 && byte_valid; c++) begin @(posedge clk); #1; end
        chk({tag, "_drained"}, 32'(byte_valid), 32'd0);
    endtask

    // Reference: scan accepted bits for the sync word, then slice the frame bytes out of the raw stream.
    task automatic run_model();
        logic [7:0] win, v;
        int i;
        exp_q.delete();
        win = 8'h00; i = 0;
        while (i < stream.size()) begin
            win = {win[6:0], stream[i]};
            i++;
            if (win == 8'hA5) begin
                win = 8'h00;
                for (int f = 0; f < 4; f++) begin
                    if (i + 8 > stream.size()) begin i = stream.size(); break; end
                    v = 8'h00;
                    for (int k = 0; k < 8; k++) v = {v[6:0], stream[i+k]};
                    exp_q.push_back({(f == 0), v});
                    i += BPB;
                end
            end
        end
    endtask

    task automatic cmp_model(input string tag);
        run_model();
        chk({tag, "_count"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(exp_q[i]));
    endtask

    task automatic rstep(input logic b);
        while ($urandom_range(0, 3) == 0) begin
            byte_ready = ($urandom_range(0, 3) != 0);
            step(logic'($urandom_range(0, 1)), 1'b0);
        end
        byte_ready = ($urandom_range(0, 3) != 0);
        step(b, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        logic [15:0] w;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_byte", 32'(byte_out), 0);
        chk("rst_sof", 32'(sof_out), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with per-byte latency and lock timing
        byte_ready = 1'b1;
        send_bits(8'h52, 7, 0);
        chk("pre_sync_unlocked", 32'(locked), 0);
        step(1'b1, 1'b1);
        chk("lock_after_sync", 32'(locked), 1);
        for (int j = 0; j < 4; j++) begin
            d = 8'(8'h11 * (j + 1));
            send_bits(d, 8, 0);
            chk("basic_valid", 32'(byte_valid), 1);
            chk("basic_byte", 32'(byte_out), 32'(d));
            chk("basic_sof", 32'(sof_out), (j == 0) ? 1 : 0);
            send_par(d, 0);
            chk("basic_locked", 32'(locked), (j < 3) ? 1 : 0);
        end
        drain("basic");
        cmp_model("basic_model");
`ifdef SERIAL_FRAME_DESER_PARITY_EN
        chk("basic_no_parity_err", 32'(parity_err), 0);
`endif

        // Enable gaps between every accepted bit
        do_reset();
        byte_ready = 1'b1;
        send_bits(8'hA5, 8, 1);
        chk("gap_lock", 32'(locked), 1);
        for (int j = 0; j < 4; j++) send_data(8'(8'h11 * (j + 1)), 1);
        chk("gap_unlock", 32'(locked), 0);
        drain("gap");
        cmp_model("gap_model");
        chk("gap_first", 32'(rx.size() > 0 ? rx[0] : 9'h0), 32'h111);

        // False patterns never lock
        do_reset();
        w = 16'h5A4B;
        for (int k = 15; k >= 0; k--) begin
            step(w[k], 1'b1);
            chk("false_no_lock", 32'(locked), 0);
        end

        // Sync at a nibble offset
        do_reset();
        byte_ready = 1'b1;
        send_bits(8'h0A, 8, 0); send_bits(8'h5F, 8, 0); send_bits(8'h3C, 8, 0);
        send_bits(8'hDE, 8, 0); send_bits(8'hF0, 8, 0); send_bits(8'h12, 8, 0);
        send_bits(8'h34, 8, 0); send_bits(8'h56, 8, 0);
        drain("offset");
        cmp_model("offset_model");
`ifndef SERIAL_FRAME_DESER_PARITY_EN
        chk("offset_first", 32'(rx.size() > 0 ? rx[0] : 9'h0), 32'h1F3);
`endif

        // Backpressure: second frame overflows the full FIFO
        do_reset();
        byte_ready = 1'b0;
        send_bits(8'hA5, 8, 0);
        for (int j = 1; j <= 4; j++) send_data(8'(j), 0);
        send_bits(8'hA5, 8, 0);
        for (int j = 5; j <= 8; j++) send_data(8'(j), 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head", 32'({sof_out, byte_out}), 32'h101);
        rx.delete();
        drain("ovf");
        chk("ovf_count", 32'(rx.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("ovf_bytes", (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'({(i == 0), 8'(i + 1)}));
        chk("ovf_sticky", 32'(overflow), 1);
        clear_err = 1'b1; step(1'b0, 1'b0); clear_err = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Clear on the same edge as a drop: set wins
        byte_ready = 1'b0;
        send_bits(8'hA5, 8, 0);
        for (int j = 1; j <= 4; j++) send_data(8'(j), 0);
        send_bits(8'hA5, 8, 0);
        clear_err = 1'b1;
        send_bits(8'h05, 8, 0);
        clear_err = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 1);

        // Asynchronous reset mid-byte, no clock edge
        send_bits(8'h05, 3, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_valid", 32'(byte_valid), 0);
        chk("arst_byte", 32'(byte_out), 0);
        chk("arst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        stream.delete(); rx.delete();
        @(posedge clk); #1;
        byte_ready = 1'b1;
        send_bits(8'hA5, 8, 0);
        for (int j = 0; j < 4; j++) send_data(8'(8'h11 * (j + 1)), 0);
        drain("arst");
        chk("arst_first", 32'(rx.size() > 0 ? rx[0] : 9'h0), 32'h111);
        cmp_model("arst_model");

`ifdef SERIAL_FRAME_DESER_PARITY_EN
        do_reset();
        byte_ready = 1'b1;
        send_bits(8'hA5, 8, 0);
        send_bits(8'h03, 8, 0); send_bits(8'h00, 1, 0);
        chk("par_ok", 32'(parity_err), 0);
        send_bits(8'h07, 8, 0); send_bits(8'h00, 1, 0);
        chk("par_err", 32'(parity_err), 1);
        clear_err = 1'b1; step(1'b0, 1'b0); clear_err = 1'b0;
        chk("par_clear", 32'(parity_err), 0);
`endif

        // Randomized stream with embedded sync words, gaps and backpressure
        do_reset();
        for (int r = 0; r < 40; r++) begin
            for (int n = $urandom_range(0, 12); n > 0; n--) rstep(logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) begin
                d = 8'hA5;
                for (int k = 7; k >= 0; k--) rstep(d[k]);
            end
            for (int n = $urandom_range(0, 40); n > 0; n--) rstep(logic'($urandom_range(0, 1)));
        end
        drain("rand");
        cmp_model("rand_model");
        chk("rand_no_overflow", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_frame_deser.md
Name: serial_frame_deser

Overview:
- Downstream consumer of the single-bit delay-line output.
- Hunts the incoming serial bit stream for an 8-bit sync word, then deserializes a fixed-length frame of bytes, MSB first.
- Buffers the bytes in a small FIFO and presents them on a valid/ready byte interface to the next stage.
- Reports lock and sticky overflow status.

Parameters:
- SYNC_WORD, 8'hA5, sync pattern that starts a frame.
- FRAME_BYTES, 4, data bytes per frame after sync (1..255).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ena  in  1  bit-sample enable; bit_in accepted only on clk edges with ena=1
- bit_in  in  1  serial data bit
- byte_out  out  8  FIFO head byte; 0 when byte_valid=0
- sof_out  out  1  head byte is first byte of a frame; 0 when byte_valid=0
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer accepts head byte when byte_valid&byte_ready
- locked  out  1  1 while in DATA state
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- clear_err  in  1  synchronous clear of sticky flags
- Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = HUNT; hunt shift register = 0; bit/byte counters = 0; FIFO empty.
  - byte_valid=0, byte_out=0, sof_out=0, locked=0, overflow=0.
  - Takes effect immediately, including mid-frame. A partial byte is discarded.
- HUNT:
  - Each accepted bit shifts into an 8-bit register: new bit enters the LSB, contents shift left.
  - If the post-shift value equals SYNC_WORD, go to DATA on that edge. locked=1 from the next cycle.
  - No output is produced in HUNT.
- DATA:
  - Accepted bits shift into the byte register, MSB first.
  - On the edge that samples the 8th bit of a byte, the assembled byte is pushed into the FIFO. sof=1 if byte index=0.
  - After the edge that pushes byte FRAME_BYTES-1: return to HUNT, clear the hunt register to 0, locked=0 from the next cycle.
  - Sync bits are never reused, so back-to-back frames need a full fresh sync word.
  - Bits with ena=0 are ignored. Counters and state hold.
- FIFO:
  - A pushed byte appears at the head with byte_valid=1 in the cycle after the push edge if the FIFO was empty (1-cycle latency).
  - Pop occurs on an edge with byte_valid&byte_ready.
  - Push when full: the byte is dropped, overflow set, and the frame continues (byte counter advances).
  - Push and pop on the same edge while full: both succeed, no overflow.
  - Push and pop on the same edge while empty is impossible, because valid is registered.
- Sticky flags:
  - clear_err=1 clears overflow on the next edge.
  - A set event on the same edge as clear_err wins (flag stays 1).

Optional Feature:
- Macro: SERIAL_FRAME_DESER_PARITY_EN.
- Defined:
  - Each data byte is followed by a 9th parity bit. Even parity over all 9 bits is expected.
  - The push still happens on the 8th bit; the 9th bit is checked on its own edge.
  - Mismatch sets the extra output port parity_err (out, 1, sticky), which clear_err clears with the same set-wins rule.
  - Frame end occurs after the parity bit of the last byte.
- Undefined:
  - 8 bits per byte.
  - The parity_err port does not exist.

Test Plan:
- Reset values: assert rst_n=0 mid-DATA with 3 bits of a byte received, asynchronously, no clk edge -> locked=0, byte_valid=0, byte_out=0, overflow=0 immediately. Restart with A5,11 -> byte 11 received cleanly.
- Basic frame: ena=1, byte_ready=1, stream A5,11,22,33,44 MSB first -> locked=1 after the 8th bit; bytes 11(sof=1),22,33,44(sof=0) each valid 1 cycle after their 8th bit; locked=0 after the 32nd data bit.
- Enable gaps: same stream with ena=0 on every other cycle -> identical byte sequence; no byte or state change on ena=0 cycles.
- Sync alignment and false patterns:
  - Stream 5A,4B -> never locks.
  - Stream 0A,5F -> A5 found at bit offset 4; locks; the next 8 bits (low nibble F plus next nibble) form byte 0.
- Backpressure/overflow: byte_ready=0, two frames A5,01..04,A5,05..08 -> FIFO holds 01..04, overflow=1. Drain with ready=1 -> 01,02,03,04 only. Pulse clear_err -> overflow=0. Pulse clear_err on the same edge as a drop -> overflow stays 1.
- Parity (macro defined): A5, then 8'h03+parity 0, then 8'h07+parity 0 -> 03 with no error, 07 sets parity_err=1. Clear -> 0.
